pgm_sched: RTL and testbench
============================

# pgm_sched

Replay scheduler and localbus register file for the packet generator's 144x128 packet RAM. It holds the generator configuration written over localbus, sequences RAM reads to replay one stored packet N times or continuously with a programmable inter-packet gap, and drives the 134-bit packet stream toward the next module. It sits between the RAM read port and the generator's output, and honours downstream almost-full at packet boundaries.

## Interface
- ADDR_W, 7, RAM address width (128 words)
- GAP_W, 16, inter-packet gap counter width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_cs  in  1  localbus chip select, held until ack seen
- cfg_rw  in  1  0 write, 1 read
- cfg_addr  in  16  register word address
- cfg_wdata  in  32  write data
- cfg_ack  out  1  one-cycle access acknowledge
- cfg_rdata  out  32  read data, valid with cfg_ack
- wr_busy  in  1  RAM loader active; replay start forbidden
- ram_rd  out  1  RAM read strobe
- ram_raddr  out  ADDR_W  RAM read address
- ram_rdata  in  144  RAM data, valid 1 cycle after ram_rd
- out_data  out  134  packet word; [133:132] 01 head, 11 middle, 10 tail
- out_data_wr  out  1  out_data valid
- out_valid_wr  out  1  packet-valid strobe, with tail word
- out_valid  out  1  packet valid flag, 1 when out_valid_wr
- in_alf  in  1  downstream almost-full

## Operation
- Registers: 0x0 CTRL (bit0 START self-clearing, bit1 STOP self-clearing, bit2 CONT), 0x1 START_ADDR[6:0], 0x2 END_ADDR[6:0], 0x3 PKT_NUM[31:0], 0x4 GAP[15:0], 0x5 STATUS RO (bit0 BUSY, bit1 ERR, sticky, cleared by write of 1 to bit1), 0x6 SENT_CNT RO, cleared by any write. Undefined addresses read 0, writes ignored. All reset to 0.
- Localbus: cs sampled high with ack low → access performed, cfg_ack=1 next cycle for one cycle; no new access until cs drops. Writes to 0x1–0x4 while BUSY are ignored.
- FSM: IDLE, WAIT, READ, DRAIN, GAP.
  - IDLE: START with wr_busy=0, END_ADDR ≥ START_ADDR, and (PKT_NUM≠0 or CONT) → WAIT, BUSY=1, pkt counter=0. Otherwise START sets ERR, stays IDLE.
  - WAIT: in_alf=0 and STOP not pending → READ, raddr=START_ADDR. STOP pending → IDLE.
  - READ: ram_rd=1 each cycle, raddr+1 per cycle through END_ADDR inclusive → DRAIN.
  - DRAIN: last word emitted; pkt counter+1, SENT_CNT+1 (saturates at 0xFFFFFFFF). Not CONT and counter==PKT_NUM, or STOP pending → IDLE, BUSY=0; else GAP (or WAIT if GAP=0).
  - GAP: count GAP cycles → WAIT.
- STOP sets a pending flag; current packet always completes; no mid-packet abort. in_alf ignored once READ entered.
- out_data = ram_rdata[133:0]; bits [143:134] discarded. The tail word (header 10) carries out_valid_wr=out_valid=1; the block does not check headers.

## Timing
- Reset: all outputs 0, FSM IDLE, all registers 0, pending STOP cleared. Reset mid-packet truncates the packet; no tail emitted.
- out_data_wr asserted exactly 2 cycles after matching ram_rd (1 RAM + 1 output register); packet of L=END−START+1 words emits L contiguous cycles.
- START write ack cycle → first ram_rd ≥2 cycles later (IDLE→WAIT→READ) when in_alf=0.
- Gap: next packet's first ram_rd is issued no earlier than GAP+3 cycles after previous last ram_rd; more if in_alf high.
- START while BUSY ignored, ERR unchanged. START and STOP in same write: STOP wins, no packet sent.
- SENT_CNT clear-by-write coinciding with increment: clear wins.

## Test plan
- START=0x10, END=0x13, PKT_NUM=3, GAP=5, CTRL=0x1 → three 4-word packets, tail with out_valid_wr, SENT_CNT=3, BUSY falls, 2-cycle ram_rd→out_data_wr latency checked.
- in_alf=1 before START, released after 20 cycles → no ram_rd while high; first ram_rd ≤2 cycles after release; in_alf raised mid-packet does not stall it.
- CONT=1, STOP written mid-packet → that packet completes with tail, no further ram_rd, BUSY=0.
- END=0x05, START=0x08, START → ERR=1, no ram_rd; START with wr_busy=1 → ERR=1; write 0x2 to STATUS clears ERR.
- START_ADDR=END_ADDR=0x7F single-word packet, PKT_NUM=2, GAP=0 → two 1-word packets, no address wrap, raddr never exceeds 0x7F.
- Reset asserted during READ → all outputs 0 within reset, registers 0, no tail afterwards; localbus read 0x5 after reset returns 0.

Source files
------------

// File: rtl/pgm_sched.sv
// pgm_sched: replay scheduler and localbus register file for the packet
// generator's 144x128 packet RAM.
//
// Replays the RAM window START_ADDR..END_ADDR as one packet, PKT_NUM times
// or continuously (CONT). Consecutive packets are separated by GAP idle
// cycles. Downstream almost-full is honoured only at packet boundaries.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_cs/rw/addr/wdata    localbus request (cs held until ack seen)
//   cfg_ack, cfg_rdata      one-cycle acknowledge, read data valid with ack
//   wr_busy                 RAM loader active; START is refused while high
//   ram_rd, ram_raddr       RAM read strobe and address
//   ram_rdata               RAM data, valid one cycle after ram_rd
//   out_data, out_data_wr   134-bit packet word and its write strobe
//   out_valid_wr, out_valid packet-valid strobe/flag, asserted with the tail
//   in_alf                  downstream almost-full
module pgm_sched #(
  parameter int ADDR_W = 7,
  parameter int GAP_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_cs,
  input  logic              cfg_rw,
  input  logic [15:0]       cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic              cfg_ack,
  output logic [31:0]       cfg_rdata,
  input  logic              wr_busy,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [143:0]      ram_rdata,
  output logic [133:0]      out_data,
  output logic              out_data_wr,
  output logic              out_valid_wr,
  output logic              out_valid,
  input  logic              in_alf
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READ,
    ST_DRAIN,
    ST_GAP
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

  state_t              state_q, state_d;
  logic                cs_seen_q, cs_seen_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                cont_q, cont_d;
  logic [ADDR_W-1:0]   start_addr_q, start_addr_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
  logic [31:0]         pkt_num_q, pkt_num_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                err_q, err_d;
  logic [31:0]         sent_cnt_q, sent_cnt_d;
  logic                start_pulse_q, start_pulse_d;
  logic                stop_pulse_q, stop_pulse_d;
  logic                stop_pend_q, stop_pend_d;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                rd_q, rd_d;
  logic                last_q, last_d;
  logic                rd_d1_q, rd_d1_d;
  logic                last_d1_q, last_d1_d;
  logic                dout_wr_q, dout_wr_d;
  logic [133:0]        dout_q, dout_d;
  logic                vld_q, vld_d;

  logic                busy;
  logic                access;
  logic                sent_clr;
  logic                stop_now;
  logic [31:0]         pkt_inc;
  logic                unused_ram_bits;

  assign busy     = (state_q != ST_IDLE);
  // One access per cs assertion: only the first sampled-high cycle counts.
  assign access   = cfg_cs && !cs_seen_q;
  assign stop_now = stop_pend_q || stop_pulse_q;
  assign pkt_inc  = pkt_cnt_q + 32'd1;

  assign unused_ram_bits = ^ram_rdata[143:134];

  always_comb begin
    state_d       = state_q;
    cs_seen_d     = cfg_cs;
    ack_d         = 1'b0;
    rdata_d       = '0;
    cont_d        = cont_q;
    start_addr_d  = start_addr_q;
    end_addr_d    = end_addr_q;
    pkt_num_d     = pkt_num_q;
    gap_d         = gap_q;
    err_d         = err_q;
    sent_cnt_d    = sent_cnt_q;
    start_pulse_d = 1'b0;
    stop_pulse_d  = 1'b0;
    stop_pend_d   = stop_pend_q;
    pkt_cnt_d     = pkt_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    raddr_d       = raddr_q;
    sent_clr      = 1'b0;

    // Localbus register access
    if (access) begin
      ack_d = 1'b1;
      if (cfg_rw) begin
        case (cfg_addr)
          16'h0:   rdata_d = {29'd0, cont_q, 2'b00};
          16'h1:   rdata_d = 32'(start_addr_q);
          16'h2:   rdata_d = 32'(end_addr_q);
          16'h3:   rdata_d = pkt_num_q;
          16'h4:   rdata_d = 32'(gap_q);
          16'h5:   rdata_d = {30'd0, err_q, busy};
          16'h6:   rdata_d = sent_cnt_q;
          default: rdata_d = '0;
        endcase
      end else begin
        case (cfg_addr)
          16'h0: begin
            cont_d        = cfg_wdata[2];
            start_pulse_d = cfg_wdata[0];
            stop_pulse_d  = cfg_wdata[1];
          end
          16'h1: if (!busy) start_addr_d = cfg_wdata[ADDR_W-1:0];
          16'h2: if (!busy) end_addr_d = cfg_wdata[ADDR_W-1:0];
          16'h3: if (!busy) pkt_num_d = cfg_wdata;
          16'h4: if (!busy) gap_d = cfg_wdata[GAP_W-1:0];
          16'h5: if (cfg_wdata[1]) err_d = 1'b0;
          16'h6: sent_clr = 1'b1;
          default: ;
        endcase
      end
    end

    // STOP only matters while a replay is running; it never aborts a packet.
    if (stop_pulse_q && busy) stop_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        // START and STOP in the same write: STOP wins, nothing is started.
        if (start_pulse_q && !stop_pulse_q) begin
          if (!wr_busy && (end_addr_q >= start_addr_q) &&
              ((pkt_num_q != 32'd0) || cont_q)) begin
            state_d   = ST_WAIT;
            pkt_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (stop_now) begin
          state_d     = ST_IDLE;
          stop_pend_d = 1'b0;
        end else if (!in_alf) begin
          state_d = ST_READ;
          raddr_d = start_addr_q;
        end
      end
      ST_READ: begin
        // Stop on END_ADDR without incrementing so 0x7F never wraps.
        if (raddr_q == end_addr_q) state_d = ST_DRAIN;
        else                       raddr_d = raddr_q + ADDR_ONE;
      end
      ST_DRAIN: begin
        pkt_cnt_d = pkt_inc;
        if (sent_cnt_q != 32'hFFFF_FFFF) sent_cnt_d = sent_cnt_q + 32'd1;
        // PKT_NUM==0 with CONT dropped mid-run ends after this packet.
        if (stop_now || (!cont_q && ((pkt_inc == pkt_num_q) || (pkt_num_q == 32'd0)))) begin
          state_d     = ST_IDLE;
          stop_pend_d = 1'b0;
        end else if (gap_q == '0) begin
          state_d = ST_WAIT;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if ((gap_cnt_q + GAP_ONE) == gap_q) state_d = ST_WAIT;
        else                                gap_cnt_d = gap_cnt_q + GAP_ONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clearing SENT_CNT takes priority over a same-cycle increment.
    if (sent_clr) sent_cnt_d = '0;
  end

  // Read strobe and the two-stage (RAM + output register) data pipeline.
  always_comb begin
    rd_d      = (state_d == ST_READ);
    last_d    = (state_d == ST_READ) && (raddr_d == end_addr_q);
    rd_d1_d   = rd_q;
    last_d1_d = last_q;
    dout_wr_d = rd_d1_q;
    dout_d    = rd_d1_q ? ram_rdata[133:0] : dout_q;
    vld_d     = rd_d1_q && last_d1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cs_seen_q     <= 1'b0;
      ack_q         <= 1'b0;
      rdata_q       <= '0;
      cont_q        <= 1'b0;
      start_addr_q  <= '0;
      end_addr_q    <= '0;
      pkt_num_q     <= '0;
      gap_q         <= '0;
      err_q         <= 1'b0;
      sent_cnt_q    <= '0;
      start_pulse_q <= 1'b0;
      stop_pulse_q  <= 1'b0;
      stop_pend_q   <= 1'b0;
      pkt_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      raddr_q       <= '0;
      rd_q          <= 1'b0;
      last_q        <= 1'b0;
      rd_d1_q       <= 1'b0;
      last_d1_q     <= 1'b0;
      dout_wr_q     <= 1'b0;
      dout_q        <= '0;
      vld_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_seen_q     <= cs_seen_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      cont_q        <= cont_d;
      start_addr_q  <= start_addr_d;
      end_addr_q    <= end_addr_d;
      pkt_num_q     <= pkt_num_d;
      gap_q         <= gap_d;
      err_q         <= err_d;
      sent_cnt_q    <= sent_cnt_d;
      start_pulse_q <= start_pulse_d;
      stop_pulse_q  <= stop_pulse_d;
      stop_pend_q   <= stop_pend_d;
      pkt_cnt_q     <= pkt_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      raddr_q       <= raddr_d;
      rd_q          <= rd_d;
      last_q        <= last_d;
      rd_d1_q       <= rd_d1_d;
      last_d1_q     <= last_d1_d;
      dout_wr_q     <= dout_wr_d;
      dout_q        <= dout_d;
      vld_q         <= vld_d;
    end
  end

  assign cfg_ack      = ack_q;
  assign cfg_rdata    = rdata_q;
  assign ram_rd       = rd_q;
  assign ram_raddr    = raddr_q;
  assign out_data     = dout_q;
  assign out_data_wr  = dout_wr_q;
  assign out_valid_wr = vld_q;
  assign out_valid    = vld_q;

endmodule

// File: tb/tb_pgm_sched.sv
// tb_pgm_sched: self-checking bench for pgm_sched.
// A RAM model answers ram_rd one cycle later. The reference model knows the
// programmed window and expects every packet to be exactly mem[START..END]
// in order, tail flagged on END, with the latency and spacing rules applied.
module tb_pgm_sched;
  localparam int ADDR_W = 7;
  localparam int GAP_W  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_cs, cfg_rw;
  logic [15:0]   cfg_addr;
  logic [31:0]   cfg_wdata;
  logic          cfg_ack;
  logic [31:0]   cfg_rdata;
  logic          wr_busy;
  logic          ram_rd;
  logic [ADDR_W-1:0] ram_raddr;
  logic [143:0]  ram_rdata = '0;
  logic [133:0]  out_data;
  logic          out_data_wr, out_valid_wr, out_valid;
  logic          in_alf;

  pgm_sched #(.ADDR_W(ADDR_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_cs(cfg_cs), .cfg_rw(cfg_rw), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata), .wr_busy(wr_busy),
    .ram_rd(ram_rd), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_data_wr(out_data_wr), .out_valid_wr(out_valid_wr),
    .out_valid(out_valid), .in_alf(in_alf)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  logic [143:0] mem [0:127];
  always @(posedge clk) if (ram_rd) ram_rdata <= mem[ram_raddr];

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  int cur_start, cur_end, cur_gap;
  logic [134:0] exp_q[$];
  int rd_cyc_q[$];
  int rd_count = 0, wr_count = 0, tail_count = 0, burst_cnt = 0;
  int burst_len = 0, out_len = 0, last_rd = -1;
  int start_ack_cycle = 0, last_ack_cycle = 0, release_cycle = 0;
  bit first_rd_pending = 0, release_pending = 0, alf_block = 0;
  int alf_viol = 0;
  logic [134:0] mon_e;
  int mon_c, mon_a;

  task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_rd) begin
        if (burst_len == 0) begin
          burst_cnt++;
          if (last_rd >= 0)
            checkOutput("gap_spacing", 144'((cycle - last_rd) >= (cur_gap + 3)), 144'(1));
          if (first_rd_pending) begin
            checkOutput("start_latency", 144'((cycle - start_ack_cycle) >= 2), 144'(1));
            first_rd_pending = 0;
          end
          if (release_pending) begin
            checkOutput("alf_release", 144'((cycle - release_cycle) <= 2), 144'(1));
            release_pending = 0;
          end
        end
        if (alf_block) alf_viol++;
        mon_a = cur_start + burst_len;
        checkOutput("raddr", 144'(ram_raddr), 144'(mon_a));
        exp_q.push_back({mon_a == cur_end, mem[mon_a[6:0]][133:0]});
        rd_cyc_q.push_back(cycle);
        burst_len++;
        rd_count++;
        last_rd = cycle;
      end else if (burst_len > 0) begin
        checkOutput("burst_len", 144'(burst_len), 144'(cur_end - cur_start + 1));
        burst_len = 0;
      end

      if (out_data_wr) begin
        out_len++;
        wr_count++;
        if (exp_q.size() == 0 || rd_cyc_q.size() == 0) begin
          checkOutput("unexpected_word", 144'(1), 144'(0));
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = rd_cyc_q.pop_front();
          checkOutput("rd_to_wr_latency", 144'(cycle - mon_c), 144'(2));
          checkOutput("out_data", 144'(out_data), 144'(mon_e[133:0]));
          checkOutput("tail_strobe", 144'({out_valid_wr, out_valid}), mon_e[134] ? 144'(3) : 144'(0));
        end
        if (out_valid_wr) tail_count++;
      end else begin
        if (out_len > 0) begin
          checkOutput("out_len", 144'(out_len), 144'(cur_end - cur_start + 1));
          out_len = 0;
        end
        if (out_valid_wr || out_valid)
          checkOutput("stray_strobe", 144'({out_valid_wr, out_valid}), 144'(0));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One localbus access; caller is aligned 1 time unit after a rising edge.
  task automatic applyStimulus(input logic rw, input logic [15:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata);
    bit got;
    got = 0;
    rdata = '0;
    cfg_cs = 1'b1; cfg_rw = rw; cfg_addr = addr; cfg_wdata = wdata;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (cfg_ack) begin
        got = 1;
        rdata = cfg_rdata;
        last_ack_cycle = cycle;
      end
    end
    if (!got) checkOutput("bus_ack_timeout", 144'(0), 144'(1));
    cfg_cs = 1'b0;
    waitCycles(1);
  endtask

  task automatic regWrite(input logic [15:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    applyStimulus(1'b0, addr, data, dummy);
  endtask

  task automatic regRead(input logic [15:0] addr, output logic [31:0] data);
    applyStimulus(1'b1, addr, 32'd0, data);
  endtask

  task automatic waitIdle();
    logic [31:0] s;
    s = 32'd1;
    for (int n = 0; n < 1500 && s[0]; n++) regRead(16'h5, s);
    if (s[0]) checkOutput("busy_timeout", 144'(1), 144'(0));
    waitCycles(4);
  endtask

  task automatic waitRd(input int base);
    for (int i = 0; i < 300 && rd_count == base; i++) waitCycles(1);
    if (rd_count == base) checkOutput("rd_timeout", 144'(0), 144'(1));
  endtask

  task automatic startRun(input int s, input int e, input int n, input int g, input bit cont);
    cur_start = s; cur_end = e; cur_gap = g;
    regWrite(16'h1, 32'(s));
    regWrite(16'h2, 32'(e));
    regWrite(16'h3, 32'(n));
    regWrite(16'h4, 32'(g));
    regWrite(16'h6, 32'd0);
    last_rd = -1;
    regWrite(16'h0, {29'd0, cont, 2'b01});
    start_ack_cycle = last_ack_cycle;
    first_rd_pending = 1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ram_rd"}, 144'(ram_rd), 144'(0));
    checkOutput({tag, "_raddr"}, 144'(ram_raddr), 144'(0));
    checkOutput({tag, "_out_data"}, 144'(out_data), 144'(0));
    checkOutput({tag, "_strobes"}, 144'({out_data_wr, out_valid_wr, out_valid}), 144'(0));
    checkOutput({tag, "_bus"}, 144'({cfg_ack, cfg_rdata}), 144'(0));
  endtask

  logic [31:0] rv;
  logic [159:0] rnd;
  int tb0, rd0, wr0, b0, s, l, n, g;

  initial begin
    for (int a = 0; a < 128; a++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      mem[a] = rnd[143:0];
    end
    rst_n = 1'b0; cfg_cs = 1'b0; cfg_rw = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    wr_busy = 1'b0; in_alf = 1'b0;
    waitCycles(3);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    waitCycles(2);

    // Three 4-word packets with a 5-cycle gap
    tb0 = tail_count;
    startRun(16, 19, 3, 5, 1'b0);
    waitIdle();
    checkOutput("t1_packets", 144'(tail_count - tb0), 144'(3));
    regRead(16'h6, rv); checkOutput("t1_sent_cnt", 144'(rv), 144'(3));
    regRead(16'h5, rv); checkOutput("t1_status", 144'(rv), 144'(0));
    regRead(16'h3, rv); checkOutput("t1_pkt_num", 144'(rv), 144'(3));
    regRead(16'h4, rv); checkOutput("t1_gap", 144'(rv), 144'(5));
    checkOutput("t1_drained", 144'(exp_q.size()), 144'(0));

    // Almost-full held before start, then raised mid-packet
    tb0 = tail_count;
    in_alf = 1'b1; alf_block = 1;
    startRun(64, 71, 1, 0, 1'b0);
    waitCycles(20);
    rd0 = rd_count;
    alf_block = 0;
    in_alf = 1'b0;
    release_cycle = cycle;
    release_pending = 1;
    waitRd(rd0);
    in_alf = 1'b1;
    waitIdle();
    in_alf = 1'b0;
    checkOutput("t2_alf_violations", 144'(alf_viol), 144'(0));
    checkOutput("t2_packets", 144'(tail_count - tb0), 144'(1));

    // Continuous mode stopped mid-packet
    tb0 = tail_count; rd0 = rd_count;
    startRun(32, 39, 0, 2, 1'b1);
    for (int i = 0; i < 300 && tail_count == tb0; i++) waitCycles(1);
    wr0 = rd_count;
    waitRd(wr0);
    regWrite(16'h0, 32'h6);
    b0 = burst_cnt;
    waitIdle();
    waitCycles(30);
    checkOutput("t3_no_new_packet", 144'(burst_cnt), 144'(b0));
    checkOutput("t3_whole_packets", 144'(rd_count - rd0), 144'((tail_count - tb0) * 8));
    regRead(16'h5, rv); checkOutput("t3_status", 144'(rv), 144'(0));
    regRead(16'h6, rv); checkOutput("t3_sent_cnt", 144'(rv), 144'(tail_count - tb0));
    regWrite(16'h0, 32'h0);

    // Error cases
    rd0 = rd_count;
    regWrite(16'h1, 32'h08); regWrite(16'h2, 32'h05); regWrite(16'h3, 32'd1);
    regWrite(16'h0, 32'h1);
    waitCycles(10);
    regRead(16'h5, rv); checkOutput("t4_err_range", 144'(rv), 144'(2));
    regWrite(16'h5, 32'h2);
    regRead(16'h5, rv); checkOutput("t4_err_clear", 144'(rv), 144'(0));
    regWrite(16'h2, 32'h09);
    wr_busy = 1'b1;
    regWrite(16'h0, 32'h1);
    waitCycles(10);
    wr_busy = 1'b0;
    regRead(16'h5, rv); checkOutput("t4_err_wr_busy", 144'(rv), 144'(2));
    regWrite(16'h5, 32'h2);
    regWrite(16'h0, 32'h3);
    waitCycles(10);
    regRead(16'h5, rv); checkOutput("t4_start_stop", 144'(rv), 144'(0));
    checkOutput("t4_no_reads", 144'(rd_count - rd0), 144'(0));

    // Single-word packets at the top of the RAM
    tb0 = tail_count;
    startRun(127, 127, 2, 0, 1'b0);
    waitIdle();
    checkOutput("t5_packets", 144'(tail_count - tb0), 144'(2));

    // Randomized windows, with a START and an address write while busy
    for (int it = 0; it < 5; it++) begin
      s = $urandom_range(0, 120);
      l = $urandom_range(1, 8);
      n = $urandom_range(2, 3);
      g = $urandom_range(0, 6);
      tb0 = tail_count;
      startRun(s, s + l - 1, n, g, 1'b0);
      regWrite(16'h0, 32'h1);
      regWrite(16'h1, 32'($urandom_range(0, 127)));
      waitIdle();
      checkOutput("rnd_packets", 144'(tail_count - tb0), 144'(n));
      regRead(16'h6, rv); checkOutput("rnd_sent_cnt", 144'(rv), 144'(n));
      regRead(16'h5, rv); checkOutput("rnd_status", 144'(rv), 144'(0));
      regRead(16'h1, rv); checkOutput("rnd_start_locked", 144'(rv), 144'(s));
      checkOutput("rnd_drained", 144'(exp_q.size()), 144'(0));
    end

    // Reset in the middle of a long packet
    rd0 = rd_count;
    startRun(32, 63, 1, 0, 1'b0);
    waitRd(rd0);
    waitCycles(5);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetOutputs("midreset");
    exp_q.delete(); rd_cyc_q.delete();
    burst_len = 0; out_len = 0; first_rd_pending = 0; last_rd = -1;
    waitCycles(3);
    rst_n = 1'b1;
    wr0 = wr_count;
    waitCycles(40);
    checkOutput("no_tail_after_reset", 144'(wr_count - wr0), 144'(0));
    for (int a = 0; a < 7; a++) begin
      regRead(16'(a), rv);
      checkOutput("reg_after_reset", 144'(rv), 144'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #(10 * 80000);
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
